// File: rtl/snow_pkg.sv
// Shared constants for the snow demo: VGA timing, layer speeds/colours, cell hash.
// Pure declarations; no latency or backpressure.
package snow_pkg;

  localparam logic [9:0] H_VIS   = 10'd640;
  localparam logic [9:0] H_FP    = 10'd16;
  localparam logic [9:0] H_SYNC  = 10'd96;
  localparam logic [9:0] H_TOT   = 10'd800;
  localparam logic [9:0] H_BLANK = H_TOT - H_VIS;

  localparam logic [9:0] V_VIS   = 10'd480;
  localparam logic [9:0] V_FP    = 10'd10;
  localparam logic [9:0] V_SYNC  = 10'd2;
  localparam logic [9:0] V_TOT   = 10'd525;
  localparam logic [9:0] V_BLANK = V_TOT - V_VIS;

  localparam int NUM_LAYERS = 3;

  // Index k holds the fall speed of layer k in lines per frame.
  localparam logic [2:0][1:0] LAYER_SPEED = {2'd3, 2'd2, 2'd1};

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam rgb_t [2:0] LAYER_RGB = {
    rgb_t'{r: 2'd3, g: 2'd3, b: 2'd3},
    rgb_t'{r: 2'd2, g: 2'd2, b: 2'd2},
    rgb_t'{r: 2'd1, g: 2'd1, b: 2'd2}
  };
  localparam rgb_t BG_RGB    = rgb_t'{r: 2'd0, g: 2'd0, b: 2'd1};
  localparam rgb_t BLANK_RGB = rgb_t'{r: 2'd0, g: 2'd0, b: 2'd0};

  localparam logic [7:0] HASH_CX    = 8'd29;
  localparam logic [7:0] HASH_CY    = 8'd71;
  localparam logic [7:0] HASH_LAYER = 8'd113;

  localparam logic [7:0] UO_RESET = 8'h88;

  // TinyVGA PMOD bit order.
  function automatic logic [7:0] vga_byte(input rgb_t c, input logic hs, input logic vs);
    return {hs, c.b[0], c.g[0], c.r[0], vs, c.b[1], c.g[1], c.r[1]};
  endfunction

endpackage

// File: rtl/snow_if.sv
// Tiny Tapeout user-pin bundle; master drives the inputs, slave is the design.
// Plain wires; no latency, no flow control.
interface snow_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/snow_vga_timing.sv
// Pixel/line/frame counters with active-low syncs and a visible-area flag.
// Syncs are combinational from the counters; free-running, no backpressure.
module vga_timing #(
  parameter logic [9:0] H_VIS = 10'd640,
  parameter logic [9:0] V_VIS = 10'd480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pause,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic [9:0] frame,
  output logic       hsync,
  output logic       vsync,
  output logic       visible
);
  import snow_pkg::*;

  localparam logic [9:0] H_LAST     = H_VIS + H_BLANK - 10'd1;
  localparam logic [9:0] H_SYNC_BEG = H_VIS + H_FP;
  localparam logic [9:0] H_SYNC_END = H_SYNC_BEG + H_SYNC;
  localparam logic [9:0] V_LAST     = V_VIS + V_BLANK - 10'd1;
  localparam logic [9:0] V_SYNC_BEG = V_VIS + V_FP;
  localparam logic [9:0] V_SYNC_END = V_SYNC_BEG + V_SYNC;

  logic line_end;
  logic frame_end;

  assign line_end  = (hcount == H_LAST);
  assign frame_end = line_end && (vcount == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount <= '0;
      vcount <= '0;
      frame  <= '0;
    end else begin
      hcount <= line_end ? '0 : hcount + 10'd1;
      if (frame_end) begin
        vcount <= '0;
      end else if (line_end) begin
        vcount <= vcount + 10'd1;
      end
      // Pause freezes the animation but the raster keeps scanning.
      if (frame_end && !pause) begin
        frame <= frame + 10'd1;
      end
    end
  end

  assign hsync   = !((hcount >= H_SYNC_BEG) && (hcount < H_SYNC_END));
  assign vsync   = !((vcount >= V_SYNC_BEG) && (vcount < V_SYNC_END));
  assign visible = (hcount < H_VIS) && (vcount < V_VIS);

endmodule

// File: rtl/snow_top.sv
// Falling-snow VGA generator: three hashed parallax layers, no frame buffer.
// uo_out registered one clock after the counters; free-running, no backpressure.
module snow_top #(
  parameter logic [9:0] H_VIS = 10'd640,
  parameter logic [9:0] V_VIS = 10'd480
) (
  input logic   clk,
  input logic   rst_n,
  snow_if.slave bus
);
  import snow_pkg::*;

  logic [9:0] hcount;
  logic [9:0] vcount;
  logic [9:0] frame;
  logic       hsync;
  logic       vsync;
  logic       visible;
  logic [2:0] density;
  logic [2:0] lit;
  rgb_t       rgb;
  logic [7:0] uo_q;

  vga_timing #(.H_VIS(H_VIS), .V_VIS(V_VIS)) u_timing (
    .clk     (clk),
    .rst_n   (rst_n),
    .pause   (bus.ui_in[2]),
    .hcount  (hcount),
    .vcount  (vcount),
    .frame   (frame),
    .hsync   (hsync),
    .vsync   (vsync),
    .visible (visible)
  );

  assign density = {1'b0, bus.ui_in[1:0]} + 3'd1;

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
    logic [8:0] drop;
    logic [8:0] ly;
    logic [7:0] h;
    logic [3:0] ox;
    logic [3:0] oy;

    // Only the low 9 bits of frame*speed matter: the layer scrolls mod 512.
    assign drop = frame[8:0] * {7'd0, LAYER_SPEED[k]};
    assign ly   = vcount[8:0] - drop;
    assign h    = HASH_CX * {2'd0, hcount[9:4]}
                + HASH_CY * {3'd0, ly[8:4]}
                + HASH_LAYER * 8'(k);
    assign ox   = {h[2:0], 1'b0};
    assign oy   = {h[4:3], h[0], 1'b0};

    assign lit[k] = (h[7:5] < density)
                 && ((hcount[3:0] == ox) || (hcount[3:0] == ox + 4'd1))
                 && ((ly[3:0] == oy) || (ly[3:0] == oy + 4'd1));
  end

  always_comb begin
    rgb = BG_RGB;
    if (!visible) begin
      rgb = BLANK_RGB;
    end else if (lit[2]) begin
      rgb = LAYER_RGB[2];
    end else if (lit[1]) begin
      rgb = LAYER_RGB[1];
    end else if (lit[0]) begin
      rgb = LAYER_RGB[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_q <= UO_RESET;
    end else begin
      uo_q <= vga_byte(rgb, hsync, vsync);
    end
  end

  assign bus.uo_out  = uo_q;
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[7:3], vcount[9], frame[9]};

endmodule

// File: tb/tb_snow_top.sv
// Self-checking bench for snow_top on a shrunk raster (80x16 visible).
// Reference model computes each pixel straight from the arithmetic rules.
module tb_snow_top;

  localparam int HV = 80;
  localparam int VV = 16;
  localparam int HT = HV + 160;
  localparam int VT = VV + 45;
  localparam int FRAME_CYC = HT * VT;
  localparam int RED [3] = '{1, 2, 3};
  localparam int GRN [3] = '{1, 2, 3};
  localparam int BLU [3] = '{2, 2, 3};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snow_if bus ();

  snow_top #(.H_VIS(10'(HV)), .V_VIS(10'(VV))) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int mh = 0;
  int mv = 0;
  int mfr = 0;
  logic [7:0] frame_b [FRAME_CYC];

  function automatic bit layer_on(int x, int y, int fr, int k, int dens);
    int ly, h, ox, oy, px, py;
    ly = (((y - fr * (k + 1)) % 512) + 512) % 512;
    h  = (29 * (x / 16) + 71 * (ly / 16) + 113 * k) % 256;
    if (h / 32 >= dens) return 1'b0;
    ox = (h % 8) * 2;
    oy = ((h / 8) % 4) * 4 + (h % 2) * 2;
    px = x % 16;
    py = ly % 16;
    return ((px == ox) || (px == ox + 1)) && ((py == oy) || (py == oy + 1));
  endfunction

  function automatic logic [7:0] model_pixel(int x, int y, int fr, logic [7:0] ui);
    logic [1:0] r, g, b;
    logic hs, vs;
    hs = !((x >= HV + 16) && (x < HV + 112));
    vs = !((y >= VV + 10) && (y < VV + 12));
    r = 2'd0; g = 2'd0; b = 2'd0;
    if (x < HV && y < VV) begin
      b = 2'd1;
      for (int k = 0; k < 3; k++) begin
        if (layer_on(x, y, fr, k, int'(ui[1:0]) + 1)) begin
          r = 2'(RED[k]); g = 2'(GRN[k]); b = 2'(BLU[k]);
        end
      end
    end
    return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
  endfunction

  // One rising edge; returns the byte the model expects after it.
  task automatic tick(output logic [7:0] exp);
    exp = model_pixel(mh, mv, mfr, bus.ui_in);
    @(posedge clk);
    #1;
    if (mh == HT - 1) begin
      mh = 0;
      if (mv == VT - 1) begin
        mv = 0;
        if (!bus.ui_in[2]) mfr = (mfr + 1) % 1024;
      end else begin
        mv++;
      end
    end else begin
      mh++;
    end
  endtask

  task automatic sync_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mh = 0; mv = 0; mfr = 0;
  endtask

  task automatic test_reset();
    bus.ena = 1'b1;
    bus.ui_in = 8'h00;
    bus.uio_in = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.uo_out !== 8'h88) begin
      errors++; $display("FAIL reset_uo_out: got %h want 88", bus.uo_out);
    end
    checks++;
    if (bus.uio_out !== 8'h00) begin
      errors++; $display("FAIL reset_uio_out: got %h want 00", bus.uio_out);
    end
    checks++;
    if (bus.uio_oe !== 8'h00) begin
      errors++; $display("FAIL reset_uio_oe: got %h want 00", bus.uio_oe);
    end
  endtask

  task automatic test_first_pixel();
    logic [7:0] e;
    bus.ui_in = 8'h00;
    rst_n = 1'b1;
    mh = 0; mv = 0; mfr = 0;
    tick(e);
    checks++;
    if (bus.uo_out !== 8'hBC) begin
      errors++; $display("FAIL first_pixel: got %h want BC", bus.uo_out);
    end
    tick(e);
    tick(e);
    checks++;
    if (bus.uo_out !== 8'hC8) begin
      errors++; $display("FAIL pixel_2_0: got %h want C8", bus.uo_out);
    end
  endtask

  task automatic test_hsync();
    logic [7:0] e;
    int low, start, falls, bad_sync, bad_blank, bad_model;
    logic prev;
    low = 0; start = 0; falls = 0; bad_sync = 0; bad_blank = 0; bad_model = 0;
    prev = 1'b1;
    for (int edge_n = 4; edge_n <= HT; edge_n++) begin
      tick(e);
      if (bus.uo_out !== e) bad_model++;
      if (bus.uo_out[7] === 1'b0) begin
        if (prev) falls++;
        if (low == 0) start = edge_n;
        low++;
        if (bus.uo_out !== 8'h08) bad_sync++;
      end else if ((edge_n - 1) >= HV && bus.uo_out !== 8'h88) begin
        bad_blank++;
      end
      prev = bus.uo_out[7];
    end
    checks++;
    if (low !== 96) begin
      errors++; $display("FAIL hsync_width: got %0d want 96", low);
    end
    checks++;
    if (start !== HV + 17) begin
      errors++; $display("FAIL hsync_start: got %0d want %0d", start, HV + 17);
    end
    checks++;
    if (falls !== 1) begin
      errors++; $display("FAIL hsync_pulses: got %0d want 1", falls);
    end
    checks++;
    if (bad_sync !== 0) begin
      errors++; $display("FAIL hsync_value: %0d cycles not 08, want 0", bad_sync);
    end
    checks++;
    if (bad_blank !== 0) begin
      errors++; $display("FAIL h_blank_value: %0d cycles not 88, want 0", bad_blank);
    end
    checks++;
    if (bad_model !== 0) begin
      errors++; $display("FAIL line0_model: %0d mismatching cycles, want 0", bad_model);
    end
  endtask

  task automatic test_density();
    logic [7:0] e;
    int cnt_dut [4];
    int cnt_mod [4];
    int x, y;
    for (int d = 0; d < 4; d++) begin
      repeat (10) tick(e);
      // Reset lands on a visible pixel so an asynchronous clear is observable.
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.uo_out !== 8'h88) begin
        errors++; $display("FAIL async_reset_d%0d: got %h want 88", d, bus.uo_out);
      end
      @(posedge clk);
      #1;
      bus.ui_in = {5'($urandom_range(31, 0)), 1'b1, 2'(d)};
      rst_n = 1'b1;
      mh = 0; mv = 0; mfr = 0;
      cnt_dut[d] = 0;
      cnt_mod[d] = 0;
      for (int i = 0; i < 15 * HT + 40; i++) begin
        x = mh; y = mv;
        tick(e);
        if (x < HV && y < VV) begin
          if ((bus.uo_out & 8'h77) != 8'h40 && (bus.uo_out & 8'h77) != 8'h00) cnt_dut[d]++;
          if ((e & 8'h77) != 8'h40 && (e & 8'h77) != 8'h00) cnt_mod[d]++;
        end
      end
      checks++;
      if (cnt_dut[d] !== cnt_mod[d]) begin
        errors++; $display("FAIL lit_count_d%0d: got %0d want %0d", d, cnt_dut[d], cnt_mod[d]);
      end
    end
    for (int d = 1; d < 4; d++) begin
      checks++;
      if (!(cnt_dut[d] > cnt_dut[d-1])) begin
        errors++;
        $display("FAIL density_increase_%0d: got %0d want more than %0d", d, cnt_dut[d], cnt_dut[d-1]);
      end
    end
  endtask

  task automatic test_random_frame();
    logic [7:0] e;
    int bad, vlow, vstart;
    bad = 0; vlow = 0; vstart = 0;
    bus.ui_in = 8'h00;
    sync_reset();
    for (int i = 1; i <= FRAME_CYC; i++) begin
      if ($urandom_range(15, 0) == 0) begin
        bus.ui_in = {5'($urandom_range(31, 0)), 1'b0, 2'($urandom_range(3, 0))};
        bus.uio_in = 8'($urandom_range(255, 0));
        bus.ena = 1'($urandom_range(1, 0));
      end
      tick(e);
      if (bus.uo_out !== e) bad++;
      if (bus.uo_out[3] === 1'b0) begin
        if (vlow == 0) vstart = i;
        vlow++;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL random_frame_model: %0d mismatching cycles, want 0", bad);
    end
    checks++;
    if (vlow !== 2 * HT) begin
      errors++; $display("FAIL vsync_width: got %0d want %0d", vlow, 2 * HT);
    end
    checks++;
    if (vstart !== (VV + 10) * HT + 1) begin
      errors++; $display("FAIL vsync_start: got %0d want %0d", vstart, (VV + 10) * HT + 1);
    end
  endtask

  task automatic test_pause();
    logic [7:0] e;
    logic [7:0] first_a;
    int bad_a, bad_b, bad_c, diff_ab, diff_bc;
    logic [7:0] c_30;
    bad_a = 0; bad_b = 0; bad_c = 0; diff_ab = 0; diff_bc = 0;
    first_a = 8'h00; c_30 = 8'h00;
    bus.ui_in = 8'h04;
    // Frame A: paused; keep only a running comparison against frame B later.
    for (int i = 0; i < FRAME_CYC; i++) begin
      tick(e);
      if (bus.uo_out !== e) bad_a++;
      frame_b[i] = bus.uo_out;
      if (i == 0) first_a = bus.uo_out;
    end
    for (int i = 0; i < FRAME_CYC; i++) begin
      if (i == FRAME_CYC / 2) bus.ui_in = 8'h00;
      tick(e);
      if (bus.uo_out !== e) bad_b++;
      if (bus.uo_out !== frame_b[i]) diff_ab++;
      frame_b[i] = bus.uo_out;
    end
    for (int i = 0; i < 4 * HT; i++) begin
      tick(e);
      if (bus.uo_out !== e) bad_c++;
      if (bus.uo_out !== frame_b[i]) diff_bc++;
      if (i == 3 * HT) c_30 = bus.uo_out;
    end
    checks++;
    if (bad_a !== 0) begin
      errors++; $display("FAIL pause_frame_a_model: %0d mismatches, want 0", bad_a);
    end
    checks++;
    if (bad_b !== 0) begin
      errors++; $display("FAIL pause_frame_b_model: %0d mismatches, want 0", bad_b);
    end
    checks++;
    if (diff_ab !== 0) begin
      errors++; $display("FAIL pause_hold: %0d pixels differ, want 0 (first A %h)", diff_ab, first_a);
    end
    checks++;
    if (diff_bc == 0) begin
      errors++; $display("FAIL unpaused_advance: got 0 differing pixels want nonzero");
    end
    checks++;
    if (bad_c !== 0) begin
      errors++; $display("FAIL frame_c_model: %0d mismatches, want 0", bad_c);
    end
    checks++;
    if (frame_b[2 * HT] !== 8'hBC) begin
      errors++; $display("FAIL frame_b_0_2: got %h want BC", frame_b[2 * HT]);
    end
    checks++;
    if (frame_b[3 * HT] !== 8'hC8) begin
      errors++; $display("FAIL frame_b_0_3: got %h want C8", frame_b[3 * HT]);
    end
    checks++;
    if (c_30 !== 8'hBC) begin
      errors++; $display("FAIL frame_c_0_3_shift: got %h want BC", c_30);
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_hsync();
    test_density();
    test_random_frame();
    test_pause();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
